// File: rtl/params_pkg.sv
// Shared panel parameters for the multimem write path.
// BYTES_PER_PIXEL: default bytes stored per panel pixel.
package params_pkg;
  localparam int BYTES_PER_PIXEL = 2;
endpackage

// File: rtl/multimem_wr_arbiter_if.sv
// Bundle of requester, fill-sweep and multimem port-A signals.
// slave: arbiter side; master: requesters / RAM-side driver.
interface multimem_wr_arbiter_if #(
  parameter int AW = 12
);
  logic          req0_valid;
  logic [AW-1:0] req0_addr;
  logic [7:0]    req0_data;
  logic          req0_ready;
  logic          req1_valid;
  logic [AW-1:0] req1_addr;
  logic [7:0]    req1_data;
  logic          req1_ready;
  logic          clear_start;
  logic [7:0]    clear_value;
  logic          clear_busy;
  logic          clear_done;
  logic [AW-1:0] ram_a_address;
  logic [7:0]    ram_a_data_in;
  logic          ram_a_clk_enable;
  logic          ram_a_wr;

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    input  clear_start, clear_value,
    output req0_ready, req1_ready,
    output clear_busy, clear_done,
    output ram_a_address, ram_a_data_in,
    output ram_a_clk_enable, ram_a_wr
  );

  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    output clear_start, clear_value,
    input  req0_ready, req1_ready,
    input  clear_busy, clear_done,
    input  ram_a_address, ram_a_data_in,
    input  ram_a_clk_enable, ram_a_wr
  );
endinterface

// File: rtl/multimem_wr_arbiter.sv
// Round-robin two-requester byte write arbiter onto multimem port A,
// with optional fill sweep (macro MULTIMEM_WR_ARBITER_CLEAR_EN).
// Ports: clk, reset (sync, active-high), bus (slave): req0/req1
// valid/addr/data/ready, clear_start/value/busy/done, ram_a_*.
module multimem_wr_arbiter #(
  parameter int PIXEL_WIDTH     = 64,
  parameter int PIXEL_HEIGHT    = 32,
  parameter int BYTES_PER_PIXEL = params_pkg::BYTES_PER_PIXEL
) (
  input logic                  clk,
  input logic                  reset,
  multimem_wr_arbiter_if.slave bus
);
  localparam int DEPTH = PIXEL_WIDTH * PIXEL_HEIGHT * BYTES_PER_PIXEL;
  localparam int AW    = $clog2(DEPTH);
  localparam logic [AW:0] CNT_LAST = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t        r_state, w_state_nxt;
  logic          r_last, w_last_nxt;
  logic [AW:0]   r_cnt, w_cnt_nxt;
  logic [7:0]    r_clr_val, w_clr_val_nxt;
  logic [AW-1:0] r_addr, w_addr_nxt;
  logic [7:0]    r_data, w_data_nxt;
  logic          r_we, w_we_nxt;
  logic          r_done, w_done_nxt;
  logic          w_g0, w_g1;
  logic          w_clr_go;

`ifdef MULTIMEM_WR_ARBITER_CLEAR_EN
  assign w_clr_go       = (r_state == IDLE) && bus.clear_start;
  assign bus.clear_busy = (r_state == CLEAR);
  assign bus.clear_done = r_done;
`else
  logic w_unused;
  assign w_clr_go       = 1'b0;
  assign bus.clear_busy = 1'b0;
  assign bus.clear_done = 1'b0;
  assign w_unused       = ^{bus.clear_start, r_done};
`endif

  // Reset also masks the combinational grants.
  assign bus.req0_ready = w_g0 & ~reset;
  assign bus.req1_ready = w_g1 & ~reset;

  assign bus.ram_a_address    = r_addr;
  assign bus.ram_a_data_in    = r_data;
  assign bus.ram_a_clk_enable = r_we;
  assign bus.ram_a_wr         = r_we;

  always_comb begin
    w_state_nxt   = r_state;
    w_last_nxt    = r_last;
    w_cnt_nxt     = r_cnt;
    w_clr_val_nxt = r_clr_val;
    w_addr_nxt    = r_addr;
    w_data_nxt    = r_data;
    w_we_nxt      = 1'b0;
    w_done_nxt    = 1'b0;
    w_g0          = 1'b0;
    w_g1          = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_clr_go) begin
          w_state_nxt   = CLEAR;
          w_cnt_nxt     = '0;
          w_clr_val_nxt = bus.clear_value;
        end else begin
          // On a tie, r_last names the loser of the next grant.
          if (bus.req0_valid && bus.req1_valid) begin
            w_g0 = r_last;
            w_g1 = ~r_last;
          end else begin
            w_g0 = bus.req0_valid;
            w_g1 = bus.req1_valid;
          end
          if (w_g0) begin
            w_addr_nxt = bus.req0_addr;
            w_data_nxt = bus.req0_data;
            w_we_nxt   = 1'b1;
            w_last_nxt = 1'b0;
          end else if (w_g1) begin
            w_addr_nxt = bus.req1_addr;
            w_data_nxt = bus.req1_data;
            w_we_nxt   = 1'b1;
            w_last_nxt = 1'b1;
          end
        end
      end
      CLEAR: begin
        w_addr_nxt = r_cnt[AW-1:0];
        w_data_nxt = r_clr_val;
        w_we_nxt   = 1'b1;
        if (r_cnt == CNT_LAST) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_last    <= 1'b1;
      r_cnt     <= '0;
      r_clr_val <= '0;
      r_addr    <= '0;
      r_data    <= '0;
      r_we      <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_last    <= w_last_nxt;
      r_cnt     <= w_cnt_nxt;
      r_clr_val <= w_clr_val_nxt;
      r_addr    <= w_addr_nxt;
      r_data    <= w_data_nxt;
      r_we      <= w_we_nxt;
      r_done    <= w_done_nxt;
    end
  end
endmodule

// File: tb/tb_multimem_wr_arbiter.sv
// Directed bench for multimem_wr_arbiter.
// Fill-sweep steps run only when MULTIMEM_WR_ARBITER_CLEAR_EN is set.
module tb_multimem_wr_arbiter;
`ifdef MULTIMEM_WR_ARBITER_CLEAR_EN
  localparam int PW  = 4;
  localparam int PH  = 2;
  localparam int BPP = 2;
`else
  localparam int PW  = 64;
  localparam int PH  = 32;
  localparam int BPP = 2;
`endif
  localparam int DEPTH = PW * PH * BPP;
  localparam int AW    = $clog2(DEPTH);

  logic clk;
  logic reset;
  int   n_run;
  int   n_fail;

  multimem_wr_arbiter_if #(.AW(AW)) bus ();

  multimem_wr_arbiter #(
    .PIXEL_WIDTH(PW),
    .PIXEL_HEIGHT(PH),
    .BYTES_PER_PIXEL(BPP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h exp %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.req0_valid  = 1'b0;
    bus.req1_valid  = 1'b0;
    bus.clear_start = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    idle_in();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    n_run  = 0;
    n_fail = 0;
    reset  = 1'b1;
    idle_in();
    bus.req0_addr   = '0;
    bus.req0_data   = '0;
    bus.req1_addr   = '0;
    bus.req1_data   = '0;
    bus.clear_value = '0;

    // reset state and reset overriding a valid
    repeat (2) @(negedge clk);
    bus.req0_valid = 1'b1;
    bus.req0_addr  = AW'(7);
    #1;
    chk("rst_ready0", bus.req0_ready, 0);
    tick();
    chk("rst_wr", bus.ram_a_wr, 0);
    chk("rst_ce", bus.ram_a_clk_enable, 0);
    chk("rst_addr", bus.ram_a_address, 0);
    chk("rst_busy", bus.clear_busy, 0);
    chk("rst_done", bus.clear_done, 0);
    @(negedge clk);
    reset = 1'b0;
    idle_in();

    // single write, top address, 'A'
    @(negedge clk);
    bus.req0_valid = 1'b1;
    bus.req0_addr  = AW'(DEPTH - 1);
    bus.req0_data  = 8'h41;
    #1;
    chk("s_ready0", bus.req0_ready, 1);
    chk("s_ready1", bus.req1_ready, 0);
    tick();
    chk("s_addr", bus.ram_a_address, DEPTH - 1);
    chk("s_data", bus.ram_a_data_in, 8'h41);
    chk("s_wr", bus.ram_a_wr, 1);
    chk("s_ce", bus.ram_a_clk_enable, 1);
    @(negedge clk);
    idle_in();
    tick();
    chk("s_wr_off", bus.ram_a_wr, 0);
    chk("s_ce_off", bus.ram_a_clk_enable, 0);
    chk("s_addr_hold", bus.ram_a_address, DEPTH - 1);
    chk("s_data_hold", bus.ram_a_data_in, 8'h41);

    // both valid after reset: 0,1,0,1
    do_reset();
    bus.req0_valid = 1'b1;
    bus.req0_addr  = AW'(1);
    bus.req0_data  = 8'h10;
    bus.req1_valid = 1'b1;
    bus.req1_addr  = AW'(2);
    bus.req1_data  = 8'h20;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_ready0", bus.req0_ready, (i % 2 == 0) ? 1 : 0);
      chk("rr_ready1", bus.req1_ready, (i % 2 == 0) ? 0 : 1);
      tick();
      chk("rr_wr", bus.ram_a_wr, 1);
      chk("rr_addr", bus.ram_a_address, (i % 2 == 0) ? 1 : 2);
      chk("rr_data", bus.ram_a_data_in, (i % 2 == 0) ? 8'h10 : 8'h20);
      @(negedge clk);
    end
    idle_in();

    // req1 alone twice, then tie goes to req0
    @(negedge clk);
    bus.req1_valid = 1'b1;
    bus.req1_addr  = AW'(9);
    bus.req1_data  = 8'h99;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("r1_ready1", bus.req1_ready, 1);
      tick();
      chk("r1_addr", bus.ram_a_address, 9);
      @(negedge clk);
    end
    bus.req0_valid = 1'b1;
    bus.req0_addr  = AW'(4);
    bus.req0_data  = 8'h44;
    #1;
    chk("tie_ready0", bus.req0_ready, 1);
    chk("tie_ready1", bus.req1_ready, 0);
    tick();
    chk("tie_addr", bus.ram_a_address, 4);
    chk("tie_data", bus.ram_a_data_in, 8'h44);
    @(negedge clk);
    idle_in();

`ifndef MULTIMEM_WR_ARBITER_CLEAR_EN
    // clear_start has no effect without the fill sweep
    @(negedge clk);
    bus.clear_start = 1'b1;
    bus.clear_value = 8'hAA;
    bus.req1_valid  = 1'b1;
    bus.req1_addr   = AW'(12);
    bus.req1_data   = 8'h5C;
    #1;
    chk("nc_ready1", bus.req1_ready, 1);
    tick();
    chk("nc_busy", bus.clear_busy, 0);
    chk("nc_addr", bus.ram_a_address, 12);
    chk("nc_data", bus.ram_a_data_in, 8'h5C);
    chk("nc_wr", bus.ram_a_wr, 1);
    @(negedge clk);
    idle_in();
    tick();
    chk("nc_busy2", bus.clear_busy, 0);
    chk("nc_done", bus.clear_done, 0);
    chk("nc_wr_off", bus.ram_a_wr, 0);
`else
    // sweep with a competing request in the start cycle
    do_reset();
    bus.clear_start = 1'b1;
    bus.clear_value = 8'h00;
    bus.req0_valid  = 1'b1;
    bus.req0_addr   = AW'(3);
    bus.req0_data   = 8'h77;
    #1;
    chk("cs_ready0", bus.req0_ready, 0);
    tick();
    chk("cs_busy", bus.clear_busy, 1);
    chk("cs_wr", bus.ram_a_wr, 0);
    // a second start with another value must be ignored
    @(negedge clk);
    bus.clear_value = 8'hFF;
    for (int k = 0; k < DEPTH; k++) begin
      if (k == 3) bus.clear_start = 1'b0;
      tick();
      chk("cl_wr", bus.ram_a_wr, 1);
      chk("cl_addr", bus.ram_a_address, k);
      chk("cl_data", bus.ram_a_data_in, 8'h00);
      chk("cl_busy", bus.clear_busy, (k < DEPTH - 1) ? 1 : 0);
      chk("cl_done", bus.clear_done, (k == DEPTH - 1) ? 1 : 0);
      chk("cl_ready0", bus.req0_ready, (k == DEPTH - 1) ? 1 : 0);
      @(negedge clk);
    end
    tick();
    chk("pc_addr", bus.ram_a_address, 3);
    chk("pc_data", bus.ram_a_data_in, 8'h77);
    chk("pc_wr", bus.ram_a_wr, 1);
    chk("pc_done", bus.clear_done, 0);
    @(negedge clk);
    idle_in();
    tick();
    chk("pc_wr_off", bus.ram_a_wr, 0);

    // reset in the middle of a sweep
    do_reset();
    bus.clear_start = 1'b1;
    bus.clear_value = 8'h33;
    tick();
    @(negedge clk);
    bus.clear_start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("ab_addr", bus.ram_a_address, k);
      @(negedge clk);
    end
    reset = 1'b1;
    tick();
    chk("ab_wr", bus.ram_a_wr, 0);
    chk("ab_busy", bus.clear_busy, 0);
    chk("ab_done", bus.clear_done, 0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    chk("ab_done2", bus.clear_done, 0);
    chk("ab_wr2", bus.ram_a_wr, 0);
    chk("ab_busy2", bus.clear_busy, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
